// File: rtl/pwm_comp_deadtime.sv
// Complementary PWM generator with programmable period, duty and dead time.
// Period/duty/dead-time changes are double-buffered and only take effect at
// period wrap (or whenever the block is disabled). A latched fault forces
// both gate commands off until the block is disabled with the fault gone.
module pwm_comp_deadtime #(
    parameter int CNT_W   = 8,
    parameter int DT_W    = 6,
    parameter int DEF_PER = 255,
    parameter int DEF_DT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [CNT_W-1:0] per_in,
    input  logic [DT_W-1:0]  dt_in,
    input  logic             flt,
    output logic             hi_out,
    output logic             lo_out,
    output logic             per_start,
    output logic             upd_done,
    output logic             fault
);

    localparam logic [CNT_W-1:0] DEF_PER_V = CNT_W'(DEF_PER);
    localparam logic [DT_W-1:0]  DEF_DT_V  = DT_W'(DEF_DT);
    localparam logic [DT_W-1:0]  DT_ONE    = DT_W'(1);

    typedef struct packed {
        logic [CNT_W-1:0] duty;
        logic [CNT_W-1:0] per;
        logic [DT_W-1:0]  dt;
    } cfg_t;

    typedef enum logic [1:0] {S_OFF, S_HI, S_LO, S_DEAD} state_t;

    cfg_t             act;
    cfg_t             pnd;
    cfg_t             in_cfg;
    logic             pend;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             wrap;
    logic             apply;
    logic             raw;
    logic             kill;

    state_t           state;
    state_t           state_nxt;
    logic             tgt;
    logic             tgt_nxt;
    logic [DT_W-1:0]  dtc;
    logic [DT_W-1:0]  dtc_nxt;

    assign in_cfg    = '{duty: duty_in, per: per_in, dt: dt_in};
    assign run       = ena & ~fault;
    assign wrap      = run & (cnt == act.per);
    // While disabled nothing is being switched, so updates can land any cycle.
    assign apply     = wrap | ~ena;
    // duty > per naturally yields 100% since cnt never exceeds per.
    assign raw       = (cnt < act.duty);
    assign per_start = run & (cnt == '0);
    // flt is included so the outputs drop on the same edge the fault latches.
    assign kill      = ~ena | fault | flt;

    // Period counter: free-runs 0..per while running, parked at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == act.per) ? '0 : cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Double-buffered configuration: a load in the apply cycle bypasses the
    // pending buffer so the freshest values always win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act      <= '{duty: '0, per: DEF_PER_V, dt: DEF_DT_V};
            pnd      <= '0;
            pend     <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= apply & (load | pend);
            if (load)
                pnd <= in_cfg;
            if (apply) begin
                if (load)
                    act <= in_cfg;
                else if (pend)
                    act <= pnd;
                pend <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    // Fault latch: set by flt, cleared only by disabling with flt quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault <= 1'b0;
        else if (flt)
            fault <= 1'b1;
        else if (~ena)
            fault <= 1'b0;
    end

    // Switch-state register plus registered gate commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_OFF;
            tgt    <= 1'b0;
            dtc    <= '0;
            hi_out <= 1'b0;
            lo_out <= 1'b0;
        end else begin
            state  <= state_nxt;
            tgt    <= tgt_nxt;
            dtc    <= dtc_nxt;
            hi_out <= (state_nxt == S_HI);
            lo_out <= (state_nxt == S_LO);
        end
    end

    // Next-state: every transition between sides passes through DEAD, and a
    // raw change during DEAD restarts the dead-time count toward the new side.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        dtc_nxt   = dtc;
        if (kill) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = S_DEAD;
                    tgt_nxt   = raw;
                    dtc_nxt   = act.dt;
                end
                S_HI: begin
                    if (!raw) begin
                        state_nxt = S_DEAD;
                        tgt_nxt   = 1'b0;
                        dtc_nxt   = act.dt;
                    end
                end
                S_LO: begin
                    if (raw) begin
                        state_nxt = S_DEAD;
                        tgt_nxt   = 1'b1;
                        dtc_nxt   = act.dt;
                    end
                end
                S_DEAD: begin
                    if (raw != tgt) begin
                        tgt_nxt = raw;
                        dtc_nxt = act.dt;
                    end else if (dtc <= DT_ONE) begin
                        state_nxt = tgt ? S_HI : S_LO;
                    end else begin
                        dtc_nxt = dtc - DT_ONE;
                    end
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_comp_deadtime.sv
// Directed bench for pwm_comp_deadtime: timeline of edges with hand-computed
// expected output values at chosen points.
module tb_pwm_comp_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       load;
    logic [7:0] duty_in;
    logic [7:0] per_in;
    logic [5:0] dt_in;
    logic       flt;
    logic       hi_out;
    logic       lo_out;
    logic       per_start;
    logic       upd_done;
    logic       fault;

    int n_chk   = 0;
    int n_pass  = 0;
    int t       = 0;
    int overlap = 0;
    int hi_cnt  = 0;
    int lo_cnt  = 0;
    int hi_base;
    int lo_base;

    pwm_comp_deadtime dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .load     (load),
        .duty_in  (duty_in),
        .per_in   (per_in),
        .dt_in    (dt_in),
        .flt      (flt),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .per_start(per_start),
        .upd_done (upd_done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Activity monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (hi_out && lo_out) overlap++;
        if (hi_out) hi_cnt++;
        if (lo_out) lo_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, got, exp);
    endtask

    // Advance to edge number 'target' of the current timeline, settle 1 unit.
    task automatic tick_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; load = 1'b0; flt = 1'b0;
        duty_in = '0; per_in = '0; dt_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi",   hi_out,    0);
        chk("rst_lo",   lo_out,    0);
        chk("rst_upd",  upd_done,  0);
        chk("rst_flt",  fault,     0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Defaults: duty 0, dt 4, period 256.
        t = 0; ena = 1'b1;
        tick_to(4);   chk("def_dead_lo", lo_out, 0); chk("def_dead_hi", hi_out, 0);
        tick_to(5);   chk("def_lo_on",   lo_out, 1); chk("def_hi_off",  hi_out, 0);
        tick_to(255); chk("def_ps_255",  per_start, 0);
        tick_to(256); chk("def_ps_wrap", per_start, 1);

        // Load while disabled: bypass straight into active.
        ena = 1'b0;
        tick_to(257); chk("dis_hi", hi_out, 0); chk("dis_lo", lo_out, 0);
        load = 1'b1; duty_in = 8'd100; per_in = 8'd199; dt_in = 6'd5;
        tick_to(258); chk("dis_upd", upd_done, 1);
        load = 1'b0;
        tick_to(259); chk("dis_upd_clr", upd_done, 0);

        // duty 100, per 199, dt 5.
        t = 0; ena = 1'b1;
        tick_to(5);   chk("p1_dead_hi",  hi_out, 0);
        tick_to(6);   chk("p1_hi_on",    hi_out, 1); chk("p1_lo_off", lo_out, 0);
        tick_to(100); chk("p1_hi_last",  hi_out, 1);
        tick_to(101); chk("p1_hi_off",   hi_out, 0); chk("p1_gap_lo", lo_out, 0);
        tick_to(105); chk("p1_gap_end",  lo_out, 0);
        tick_to(106); chk("p1_lo_on",    lo_out, 1);
        tick_to(199); chk("p1_ps_199",   per_start, 0);
        tick_to(200); chk("p1_ps_wrap",  per_start, 1); chk("p1_lo_wrap", lo_out, 1);
        tick_to(201); chk("p1_lo_off2",  lo_out, 0);
        tick_to(206); chk("p2_hi_on",    hi_out, 1);

        // Mid-period load of duty 50 at cnt=30: held off until wrap.
        tick_to(230);
        load = 1'b1; duty_in = 8'd50; per_in = 8'd199; dt_in = 6'd5;
        tick_to(231); load = 1'b0; chk("mid_no_upd", upd_done, 0);
        tick_to(260); chk("mid_old_duty", hi_out, 1);
        tick_to(300); chk("mid_old_end",  hi_out, 1);
        tick_to(301); chk("mid_old_off",  hi_out, 0);
        tick_to(399); chk("mid_upd_pre",  upd_done, 0);
        tick_to(400); chk("mid_upd",      upd_done, 1);
        tick_to(401); chk("mid_upd_clr",  upd_done, 0);
        tick_to(406); chk("p3_hi_on",     hi_out, 1);
        tick_to(450); chk("p3_hi_last",   hi_out, 1);
        tick_to(451); chk("p3_hi_off",    hi_out, 0);
        tick_to(456); chk("p3_lo_on",     lo_out, 1);

        // Pulse (duty 3) shorter than dead time (6): hi never asserts.
        tick_to(460);
        load = 1'b1; duty_in = 8'd3; per_in = 8'd199; dt_in = 6'd6;
        tick_to(461); load = 1'b0;
        tick_to(600); hi_base = hi_cnt;
        tick_to(601); chk("short_lo_off", lo_out, 0);
        tick_to(609); chk("short_dead",   lo_out, 0);
        tick_to(610); chk("short_lo_on",  lo_out, 1);
        tick_to(800); chk("short_no_hi",  hi_cnt - hi_base, 0);

        // dt 0: one dead clock per edge.
        tick_to(805);
        load = 1'b1; duty_in = 8'd100; per_in = 8'd199; dt_in = 6'd0;
        tick_to(806); load = 1'b0;
        tick_to(1001); chk("dt0_dead_hi", hi_out, 0); chk("dt0_dead_lo", lo_out, 0);
        tick_to(1002); chk("dt0_hi_on",   hi_out, 1);
        tick_to(1101); chk("dt0_hi_off",  hi_out, 0); chk("dt0_dead2", lo_out, 0);
        tick_to(1102); chk("dt0_lo_on",   lo_out, 1);

        // duty = per+1: hi constant, lo never.
        tick_to(1105);
        load = 1'b1; duty_in = 8'd200; per_in = 8'd199; dt_in = 6'd0;
        tick_to(1106); load = 1'b0;
        tick_to(1202); chk("full_hi_on", hi_out, 1);
        hi_base = hi_cnt; lo_base = lo_cnt;
        tick_to(1600);
        chk("full_hi_cnt", hi_cnt - hi_base, 398);
        chk("full_lo_cnt", lo_cnt - lo_base, 0);

        // Fault at cnt=40 with a pending update queued beforehand.
        tick_to(1620);
        load = 1'b1; duty_in = 8'd100; per_in = 8'd199; dt_in = 6'd5;
        tick_to(1621); load = 1'b0;
        tick_to(1640); chk("flt_pre_hi", hi_out, 1); chk("flt_pre", fault, 0);
        flt = 1'b1;
        tick_to(1641); flt = 1'b0;
        chk("flt_hi_off", hi_out, 0); chk("flt_lo_off", lo_out, 0); chk("flt_set", fault, 1);
        tick_to(1642); chk("flt_no_ps",  per_start, 0);
        tick_to(1650); chk("flt_held",   fault, 1); chk("flt_hold_hi", hi_out, 0);
        chk("flt_no_upd", upd_done, 0);
        ena = 1'b0;
        tick_to(1651); chk("flt_clr", fault, 0); chk("flt_pend_upd", upd_done, 1);
        tick_to(1652); chk("flt_upd_clr", upd_done, 0);
        ena = 1'b1;
        tick_to(1657); chk("rst_dead_hi", hi_out, 0); chk("rst_dead_lo", lo_out, 0);
        tick_to(1658); chk("restart_hi",  hi_out, 1);

        // Asynchronous reset mid-period.
        tick_to(1700); chk("pre_arst_hi", hi_out, 1);
        rst = 1'b1;
        #1;
        chk("arst_hi", hi_out, 0);
        chk("arst_lo", lo_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        chk("no_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
